cv32e40p_apu_arbiter: RTL and testbench

- Shares one APU/FPU instance (cv32e40p_fp_wrapper) between NUM_CORES cv32e40p cores in a cluster.
- Round-robin arbitration of APU requests; downstream request held stable until granted.
- Issuing core ID recorded in an in-order ID FIFO; each result routed back to the core that issued it.
- Sits between the core APU ports and the FP wrapper, replacing the per-core FPU instance.

---
 rtl/cv32e40p_apu_arbiter.sv | 136 +++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter that lets NUM_CORES cv32e40p cores share one APU/FPU.
// Issuing core IDs are kept in an in-order FIFO so each result reaches the core that issued it.
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES       = 2,
    parameter int MAX_OUTSTANDING = 1,
    parameter int NARGS           = 3,
    parameter int WOP             = 6,
    parameter int NDSFLAGS        = 15,
    parameter int NUSFLAGS        = 5,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_CORES-1:0]                 core_req_i,
    output logic [NUM_CORES-1:0]                 core_gnt_o,
    input  logic [NUM_CORES-1:0][NARGS-1:0][31:0] core_operands_i,
    input  logic [NUM_CORES-1:0][WOP-1:0]        core_op_i,
    input  logic [NUM_CORES-1:0][NDSFLAGS-1:0]   core_flags_i,
    output logic [NUM_CORES-1:0]                 core_rvalid_o,
    output logic [31:0]                          core_result_o,
    output logic [NUSFLAGS-1:0]                  core_rflags_o,
    output logic                                 fpu_req_o,
    input  logic                                 fpu_gnt_i,
    output logic [NARGS-1:0][31:0]               fpu_operands_o,
    output logic [WOP-1:0]                       fpu_op_o,
    output logic [NDSFLAGS-1:0]                  fpu_flags_o,
    input  logic                                 fpu_rvalid_i,
    input  logic [31:0]                          fpu_result_i,
    input  logic [NUSFLAGS-1:0]                  fpu_rflags_i,
    output logic [CNT_W-1:0]                     outstanding_o,
    output logic                                 err_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {ARB, HOLD} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] arb_idx, winner, head_idx;
    logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic             fifo_full, fifo_empty, accept, pop, found;
    int               cand;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // First requester at or after rr_ptr_q, wrapping modulo NUM_CORES.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        arb_idx = rr_ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            if (!found && core_req_i[IDX_W'(cand)]) begin
                arb_idx = IDX_W'(cand);
                found   = 1'b1;
            end
        end
    end

    assign winner     = (state_q == HOLD) ? lock_idx_q : arb_idx;
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = id_mem[rd_ptr_q];

    // Full blocks the request even when a pop lands in the same cycle: no rvalid-to-req path.
    assign fpu_req_o = !rst_i && (|core_req_i) && !fifo_full;
    assign accept    = fpu_req_o && fpu_gnt_i;
    assign pop       = !rst_i && fpu_rvalid_i && !fifo_empty;

    assign fpu_operands_o = core_operands_i[winner];
    assign fpu_op_o       = core_op_i[winner];
    assign fpu_flags_o    = core_flags_i[winner];
    assign core_result_o  = fpu_result_i;
    assign core_rflags_o  = fpu_rflags_i;
    assign outstanding_o  = count_q;
    assign err_o          = err_q;

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (accept) core_gnt_o[winner]   = 1'b1;
        if (pop)    core_rvalid_o[head_idx] = 1'b1;
    end

    // Once a request is shown without grant, the winner is frozen until it is accepted.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            state_d  = ARB;
            rr_ptr_d = (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + IDX_W'(1);
        end else if (fpu_req_o) begin
            state_d    = HOLD;
            lock_idx_d = winner;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (accept && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!accept && pop) count_q <= count_q - CNT_W'(1);
            if (fpu_rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    // NOTE: ID storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (accept) id_mem[wr_ptr_q] <= winner;
    end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for cv32e40p_apu_arbiter: random traffic against a queue-based reference model,
// followed by directed single-request, hold, full-FIFO, in-order and error/reset sequences.
module tb_cv32e40p_apu_arbiter;

    localparam int NC  = 3;
    localparam int MO  = 2;
    localparam int NA  = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;
    localparam int CW  = $clog2(MO + 1);

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic [NC-1:0]               core_req_i;
    logic [NC-1:0]               core_gnt_o;
    logic [NC-1:0][NA-1:0][31:0] core_operands_i;
    logic [NC-1:0][WOP-1:0]      core_op_i;
    logic [NC-1:0][NDS-1:0]      core_flags_i;
    logic [NC-1:0]               core_rvalid_o;
    logic [31:0]                 core_result_o;
    logic [NUS-1:0]              core_rflags_o;
    logic                        fpu_req_o;
    logic                        fpu_gnt_i;
    logic [NA-1:0][31:0]         fpu_operands_o;
    logic [WOP-1:0]              fpu_op_o;
    logic [NDS-1:0]              fpu_flags_o;
    logic                        fpu_rvalid_i;
    logic [31:0]                 fpu_result_i;
    logic [NUS-1:0]              fpu_rflags_i;
    logic [CW-1:0]               outstanding_o;
    logic                        err_o;

    always #5 clk_i = ~clk_i;

    cv32e40p_apu_arbiter #(
        .NUM_CORES(NC), .MAX_OUTSTANDING(MO), .NARGS(NA),
        .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
        .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o), .core_rflags_o(core_rflags_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_result_i(fpu_result_i), .fpu_rflags_i(fpu_rflags_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: issue-order queue of core IDs plus the arbitration bookkeeping.
    int m_q[$];
    int m_rr     = 0;
    bit m_locked = 1'b0;
    int m_lk     = 0;
    bit m_err    = 1'b0;
    bit pending[NC];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst_i        = 1'b0;
        core_req_i   = '0;
        fpu_gnt_i    = 1'b0;
        fpu_rvalid_i = 1'b0;
        fpu_result_i = '0;
        fpu_rflags_i = '0;
    endtask

    // Compare all outputs against the model for the current inputs, then advance the model
    // to what the next clock edge should produce.
    task automatic eval_cycle();
        int            win;
        bit            exp_req, acc, found;
        logic [NC-1:0] exp_gnt, exp_rv;
        exp_req = !rst_i && (core_req_i != '0) && (m_q.size() < MO);
        win     = m_rr;
        found   = 1'b0;
        if (m_locked) win = m_lk;
        else begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_rr + i) % NC;
                if (!found && core_req_i[c]) begin
                    win   = c;
                    found = 1'b1;
                end
            end
        end
        acc     = exp_req && fpu_gnt_i;
        exp_gnt = '0;
        exp_rv  = '0;
        if (acc) exp_gnt[win] = 1'b1;
        if (!rst_i && fpu_rvalid_i && m_q.size() > 0) exp_rv[m_q[0]] = 1'b1;

        check("fpu_req", fpu_req_o, exp_req);
        check("core_gnt", core_gnt_o, exp_gnt);
        check("core_rvalid", core_rvalid_o, exp_rv);
        check("core_result", core_result_o, fpu_result_i);
        check("core_rflags", core_rflags_o, fpu_rflags_i);
        check("outstanding", outstanding_o, m_q.size());
        check("err", err_o, m_err);
        if (exp_req) begin
            check("fpu_op", fpu_op_o, core_op_i[win]);
            check("fpu_operands", fpu_operands_o, core_operands_i[win]);
            check("fpu_flags", fpu_flags_o, core_flags_i[win]);
        end

        if (rst_i) begin
            m_q.delete();
            m_rr     = 0;
            m_locked = 1'b0;
            m_err    = 1'b0;
        end else begin
            if (fpu_rvalid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (acc) begin
                m_q.push_back(win);
                m_rr     = (win + 1) % NC;
                m_locked = 1'b0;
            end else if (exp_req) begin
                m_locked = 1'b1;
                m_lk     = win;
            end
        end
        for (int c = 0; c < NC; c++) pending[c] = core_req_i[c] && !exp_gnt[c];
    endtask

    // Cores with an ungranted request keep it and its payload; others may drop or start one.
    task automatic drive_random();
        rst_i = ($urandom_range(0, 149) == 0);
        for (int c = 0; c < NC; c++) begin
            if (!pending[c]) begin
                core_req_i[c]   = ($urandom_range(0, 2) != 0);
                core_op_i[c]    = WOP'($urandom);
                core_flags_i[c] = NDS'($urandom);
                for (int a = 0; a < NA; a++) core_operands_i[c][a] = $urandom;
            end
        end
        fpu_gnt_i    = ($urandom_range(0, 2) != 0);
        fpu_rvalid_i = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
        fpu_result_i = $urandom;
        fpu_rflags_i = NUS'($urandom);
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        core_op_i       = '0;
        core_flags_i    = '0;
        core_operands_i = '0;
        for (int c = 0; c < NC; c++) pending[c] = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("reset_outstanding", outstanding_o, 0);
        check("reset_err", err_o, 0);
        check("reset_fpu_req", fpu_req_o, 0);
        eval_cycle();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            drive_random();
            #1;
            eval_cycle();
        end

        // Single request from core 1, result three cycles later.
        next_cycle(); rst_i = 1'b1; #1; eval_cycle();
        next_cycle(); core_req_i = 3'b010; core_op_i[1] = 6'h11; fpu_gnt_i = 1'b1; #1;
        check("single_gnt", core_gnt_o, 3'b010); eval_cycle();
        next_cycle(); #1; check("single_outstanding", outstanding_o, 1); eval_cycle();
        next_cycle(); #1; eval_cycle();
        next_cycle(); fpu_rvalid_i = 1'b1; fpu_result_i = 32'h3F80_0000; #1;
        check("single_rvalid", core_rvalid_o, 3'b010);
        check("single_result", core_result_o, 32'h3F80_0000); eval_cycle();
        next_cycle(); #1; check("single_drained", outstanding_o, 0); eval_cycle();

        // Hold: core 0 waits three cycles, core 1 joins; core 0's opcode stays on the bus.
        next_cycle(); core_req_i = 3'b001; core_op_i[0] = 6'h2A; #1;
        check("hold_op_c1", fpu_op_o, 6'h2A); eval_cycle();
        next_cycle(); core_req_i = 3'b011; core_op_i[1] = 6'h15; #1;
        check("hold_op_c2", fpu_op_o, 6'h2A); eval_cycle();
        next_cycle(); core_req_i = 3'b011; #1;
        check("hold_op_c3", fpu_op_o, 6'h2A); eval_cycle();
        next_cycle(); core_req_i = 3'b011; fpu_gnt_i = 1'b1; #1;
        check("hold_first_gnt", core_gnt_o, 3'b001); eval_cycle();
        next_cycle(); core_req_i = 3'b010; fpu_gnt_i = 1'b1; #1;
        check("hold_second_gnt", core_gnt_o, 3'b010); eval_cycle();

        // FIFO now full (core 0, core 1): no request, not even in the pop cycle.
        next_cycle(); core_req_i = 3'b100; core_op_i[2] = 6'h07; fpu_gnt_i = 1'b1; #1;
        check("full_no_req", fpu_req_o, 0); check("full_no_gnt", core_gnt_o, 0); eval_cycle();
        next_cycle(); core_req_i = 3'b100; fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b1; fpu_result_i = 32'hA; #1;
        check("full_pop_no_req", fpu_req_o, 0);
        check("order_first", core_rvalid_o, 3'b001); eval_cycle();
        next_cycle(); core_req_i = 3'b100; fpu_gnt_i = 1'b1; #1;
        check("full_resume_req", fpu_req_o, 1); check("full_resume_gnt", core_gnt_o, 3'b100); eval_cycle();
        next_cycle(); fpu_rvalid_i = 1'b1; fpu_result_i = 32'hB; #1;
        check("order_second", core_rvalid_o, 3'b010);
        check("order_second_res", core_result_o, 32'hB); eval_cycle();
        next_cycle(); fpu_rvalid_i = 1'b1; #1;
        check("order_third", core_rvalid_o, 3'b100); eval_cycle();

        // Reset with one op in flight; the late response is dropped and flags an error.
        next_cycle(); core_req_i = 3'b001; fpu_gnt_i = 1'b1; #1; eval_cycle();
        next_cycle(); rst_i = 1'b1; #1; eval_cycle();
        next_cycle(); fpu_rvalid_i = 1'b1; #1;
        check("late_no_rvalid", core_rvalid_o, 0); eval_cycle();
        next_cycle(); #1; check("err_set", err_o, 1); eval_cycle();
        next_cycle(); #1; check("err_sticky", err_o, 1); eval_cycle();
        next_cycle(); rst_i = 1'b1; #1; eval_cycle();
        next_cycle(); #1; check("err_cleared", err_o, 0); eval_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
